// File: rtl/flash_word_fetch.sv
// Word fetch bridge in front of the qspi_flash byte streamer. Little-endian bytes are packed into words.
// A small prefetch FIFO serves sequential requests. Any other request restarts the flash stream.
module flash_word_fetch #(
   parameter int unsigned FIFO_DEPTH    = 2,
   parameter logic [23:0] BOOT_ADDR     = 24'h000000,
   parameter bit          BOOT_PREFETCH = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [23:0] req_addr,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic [23:0] flash_addr,
   output logic        flash_do_read,
   input  logic        flash_setup_done,
   input  logic        flash_data_ready,
   input  logic [7:0]  flash_data
);

   localparam int unsigned     PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned     CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   typedef enum logic [1:0] {
      WAIT_SETUP = 2'd0,
      RESTART    = 2'd1,
      IDLE       = 2'd2,
      WAIT_WORD  = 2'd3
   } state_t;

   state_t           state_r;
   logic [23:0]      head_addr_r;
   logic [23:0]      fill_addr_r;
   logic [23:0]      target_r;
   logic [1:0]       lane_r;
   logic [CNT_W-1:0] count_r;
   logic             stream_active_r;
   logic             pending_r;
   logic [23:0]      byte_buf_r;
   logic [31:0]      fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;

   logic [23:0] req_aligned_s;
   logic        fifo_hit_s;
   logic        fill_hit_s;
   logic        miss_s;
   logic        cap_s;
   logic        word_done_s;
   logic [31:0] word_s;
   logic [23:0] byte_buf_next_s;
   logic        fill_now_s;
   logic        stash_s;
   logic        push_s;
   logic        overflow_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_LAST) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1'b1);
      end
   endfunction

   // Classify an accepted request against the FIFO head and the word being assembled
   always_comb begin
      req_aligned_s = req_addr & 24'hFFFFFC;
      fifo_hit_s    = 1'b0;
      fill_hit_s    = 1'b0;
      miss_s        = 1'b0;
      if ((state_r == IDLE) && req_valid && req_ready) begin
         if ((count_r != CNT_ZERO) && (req_aligned_s == head_addr_r)) begin
            fifo_hit_s = 1'b1;
         end else if ((count_r == CNT_ZERO) && stream_active_r && (req_aligned_s == fill_addr_r)) begin
            fill_hit_s = 1'b1;
         end else begin
            miss_s = 1'b1;
         end
      end else begin
         fifo_hit_s = 1'b0;
         fill_hit_s = 1'b0;
         miss_s     = 1'b0;
      end
   end

   // Byte capture and word assembly; bytes are ignored while flash_do_read is low
   always_comb begin
      cap_s           = flash_do_read && flash_data_ready;
      word_done_s     = cap_s && (lane_r == 2'd3);
      word_s          = {flash_data, byte_buf_r};
      byte_buf_next_s = byte_buf_r;
      case (lane_r)
         2'd0:    byte_buf_next_s[7:0]   = flash_data;
         2'd1:    byte_buf_next_s[15:8]  = flash_data;
         2'd2:    byte_buf_next_s[23:16] = flash_data;
         default: byte_buf_next_s        = byte_buf_r;
      endcase
      // A fill hit landing on the completing word is answered directly
      fill_now_s = fill_hit_s && word_done_s;
      stash_s    = (state_r == IDLE) && word_done_s && !miss_s && !fill_now_s;
      push_s     = stash_s && ((count_r != CNT_FULL) || fifo_hit_s);
      overflow_s = stash_s && !push_s;
   end

   // Control FSM, prefetch FIFO and registered fetch/flash outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r         <= WAIT_SETUP;
         head_addr_r     <= 24'h000000;
         fill_addr_r     <= 24'h000000;
         target_r        <= 24'h000000;
         lane_r          <= 2'd0;
         count_r         <= CNT_ZERO;
         stream_active_r <= 1'b0;
         pending_r       <= 1'b0;
         byte_buf_r      <= 24'h000000;
         fifo_mem_r      <= '{default: 32'h00000000};
         rd_ptr_r        <= {PTR_W{1'b0}};
         wr_ptr_r        <= {PTR_W{1'b0}};
         req_ready       <= 1'b0;
         resp_valid      <= 1'b0;
         resp_data       <= 32'h00000000;
         flash_addr      <= 24'h000000;
         flash_do_read   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state_r)
            WAIT_SETUP: begin
               req_ready     <= 1'b0;
               flash_do_read <= 1'b0;
               if (flash_setup_done) begin
                  if (BOOT_PREFETCH) begin
                     target_r  <= BOOT_ADDR & 24'hFFFFFC;
                     pending_r <= 1'b0;
                     state_r   <= RESTART;
                  end else begin
                     state_r <= IDLE;
                  end
               end
            end
            RESTART: begin
               req_ready       <= 1'b0;
               flash_addr      <= target_r;
               flash_do_read   <= 1'b1;
               head_addr_r     <= target_r;
               fill_addr_r     <= target_r;
               lane_r          <= 2'd0;
               count_r         <= CNT_ZERO;
               rd_ptr_r        <= {PTR_W{1'b0}};
               wr_ptr_r        <= {PTR_W{1'b0}};
               stream_active_r <= 1'b1;
               pending_r       <= 1'b0;
               state_r         <= pending_r ? WAIT_WORD : IDLE;
            end
            IDLE: begin
               req_ready <= 1'b1;
               if (miss_s) begin
                  target_r      <= req_aligned_s;
                  pending_r     <= 1'b1;
                  flash_do_read <= 1'b0;
                  req_ready     <= 1'b0;
                  state_r       <= RESTART;
               end else begin
                  if (fifo_hit_s) begin
                     resp_valid  <= 1'b1;
                     resp_data   <= fifo_mem_r[rd_ptr_r];
                     rd_ptr_r    <= ptr_inc(rd_ptr_r);
                     head_addr_r <= head_addr_r + 24'd4;
                  end else if (fill_now_s) begin
                     resp_valid  <= 1'b1;
                     resp_data   <= word_s;
                     head_addr_r <= head_addr_r + 24'd4;
                     fill_addr_r <= fill_addr_r + 24'd4;
                  end else if (fill_hit_s) begin
                     req_ready <= 1'b0;
                     state_r   <= WAIT_WORD;
                  end
                  if (cap_s) begin
                     lane_r     <= lane_r + 2'd1;
                     byte_buf_r <= byte_buf_next_s;
                  end
                  if (push_s) begin
                     fifo_mem_r[wr_ptr_r] <= word_s;
                     wr_ptr_r             <= ptr_inc(wr_ptr_r);
                     fill_addr_r          <= fill_addr_r + 24'd4;
                  end
                  // FIFO full: drop the word and park the stream until the next restart
                  if (overflow_s) begin
                     flash_do_read   <= 1'b0;
                     stream_active_r <= 1'b0;
                  end
                  if (push_s && !fifo_hit_s) begin
                     count_r <= count_r + CNT_W'(1);
                  end else if (!push_s && fifo_hit_s) begin
                     count_r <= count_r - CNT_W'(1);
                  end
               end
            end
            WAIT_WORD: begin
               req_ready <= 1'b0;
               if (cap_s) begin
                  lane_r     <= lane_r + 2'd1;
                  byte_buf_r <= byte_buf_next_s;
               end
               if (word_done_s) begin
                  resp_valid  <= 1'b1;
                  resp_data   <= word_s;
                  head_addr_r <= head_addr_r + 24'd4;
                  fill_addr_r <= fill_addr_r + 24'd4;
                  state_r     <= IDLE;
               end
            end
            default: begin
               req_ready     <= 1'b0;
               flash_do_read <= 1'b0;
               state_r       <= WAIT_SETUP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flash_word_fetch.sv
// Directed bench for flash_word_fetch with a behavioural qspi_flash stand-in whose byte at address a is a[7:0].
module tb_flash_word_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [23:0] req_addr;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [23:0] flash_addr;
   logic        flash_do_read;
   logic        flash_setup_done;
   logic        flash_data_ready;
   logic [7:0]  flash_data;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   flash_word_fetch #(
      .FIFO_DEPTH   (2),
      .BOOT_ADDR    (24'h000000),
      .BOOT_PREFETCH(1'b1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_addr        (req_addr),
      .req_ready       (req_ready),
      .resp_valid      (resp_valid),
      .resp_data       (resp_data),
      .flash_addr      (flash_addr),
      .flash_do_read   (flash_do_read),
      .flash_setup_done(flash_setup_done),
      .flash_data_ready(flash_data_ready),
      .flash_data      (flash_data)
   );

   // Flash stand-in: latches flash_addr on do_read rise, 3 idle cycles, then one byte per cycle.
   // It keeps emitting on the edge where do_read falls, so one stale byte lands after each drop.
   logic        m_active;
   logic [23:0] m_ptr;
   logic [1:0]  m_delay;
   int          good_bytes;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_active         <= 1'b0;
         m_ptr            <= 24'h000000;
         m_delay          <= 2'd0;
         good_bytes       <= 0;
         flash_data_ready <= 1'b0;
         flash_data       <= 8'h00;
      end else begin
         flash_data_ready <= 1'b0;
         if (!flash_do_read) begin
            m_active <= 1'b0;
         end else if (!m_active) begin
            m_active <= 1'b1;
            m_ptr    <= flash_addr;
            m_delay  <= 2'd3;
         end else if (m_delay != 2'd0) begin
            m_delay <= m_delay - 2'd1;
         end else begin
            flash_data_ready <= 1'b1;
            flash_data       <= m_ptr[7:0];
            m_ptr            <= m_ptr + 24'd1;
            good_bytes       <= good_bytes + 1;
         end
      end
   end

   logic mon_clr;
   int   drop_cnt;
   int   resp_seen;

   always @(posedge clk) begin
      if (mon_clr) begin
         drop_cnt  <= 0;
         resp_seen <= 0;
      end else begin
         if (!flash_do_read) drop_cnt <= drop_cnt + 1;
         if (resp_valid)     resp_seen <= resp_seen + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic mon_reset();
      @(negedge clk);
      mon_clr = 1'b1;
      @(negedge clk);
      mon_clr = 1'b0;
   endtask

   task automatic wait_bytes(input int n);
      int k = 0;
      while (good_bytes < n && k < 500) begin
         @(negedge clk);
         k++;
      end
      check_eq("bytes_timeout", 32'(k < 500), 32'd1);
   endtask

   task automatic do_req(input logic [23:0] addr, output logic [31:0] data, output int lat);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("ready_timeout", 32'(n < 200), 32'd1);
      req_valid = 1'b1;
      req_addr  = addr;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 200);
      check_eq("resp_timeout", 32'(lat < 200), 32'd1);
      data = resp_data;
      @(negedge clk);
      check_eq("resp_pulse", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      int          lat;
      int          n;

      rst              = 1'b0;
      flash_setup_done = 1'b0;
      req_valid        = 1'b0;
      req_addr         = 24'h000000;
      mon_clr          = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
      check_eq("rst_resp_data", resp_data, 32'h0);
      check_eq("rst_do_read", 32'(flash_do_read), 32'd0);
      check_eq("rst_flash_addr", 32'(flash_addr), 32'h0);

      rst = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("setup_do_read", 32'(flash_do_read), 32'd0);
      check_eq("setup_req_ready", 32'(req_ready), 32'd0);
      flash_setup_done = 1'b1;

      // Boot prefetch fills the FIFO with words 0x0 and 0x4
      wait_bytes(1);
      mon_reset();
      wait_bytes(8);
      @(posedge clk);
      check_eq("boot_do_read", 32'(flash_do_read), 32'd1);
      check_eq("boot_flash_addr", 32'(flash_addr), 32'h0);
      do_req(24'h000000, d, lat);
      check_eq("t1_data", d, 32'h03020100);
      check_eq("t1_latency", 32'(lat), 32'd1);

      // Sequential requests keep the stream running
      do_req(24'h000004, d, lat);
      check_eq("t2_data4", d, 32'h07060504);
      check_eq("t2_latency4", 32'(lat), 32'd1);
      do_req(24'h000008, d, lat);
      check_eq("t2_data8", d, 32'h0B0A0908);
      do_req(24'h00000C, d, lat);
      check_eq("t2_dataC", d, 32'h0F0E0D0C);
      check_eq("t2_no_drop", 32'(drop_cnt), 32'd0);

      // Miss with a non-empty FIFO: one-cycle restart, stale byte in restart cycle ignored
      wait_bytes(20);
      @(posedge clk);
      mon_reset();
      do_req(24'h001000, d, lat);
      check_eq("t3_data", d, 32'h03020100);
      check_eq("t3_drop_cycles", 32'(drop_cnt), 32'd1);
      check_eq("t3_flash_addr", 32'(flash_addr), 32'h001000);

      // Unaligned top-of-space request, then wrap to 0 without a restart
      do_req(24'hFFFFFF, d, lat);
      check_eq("t5_data", d, 32'hFFFEFDFC);
      check_eq("t5_flash_addr", 32'(flash_addr), 32'hFFFFFC);
      mon_reset();
      do_req(24'h000000, d, lat);
      check_eq("t5_wrap_data", d, 32'h03020100);
      check_eq("t5_wrap_no_drop", 32'(drop_cnt), 32'd0);

      // Reset while waiting for a word
      mon_reset();
      n = 0;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("t6_ready_timeout", 32'(n < 200), 32'd1);
      req_valid = 1'b1;
      req_addr  = 24'h002000;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("t6_req_ready", 32'(req_ready), 32'd0);
      check_eq("t6_resp_valid", 32'(resp_valid), 32'd0);
      check_eq("t6_resp_data", resp_data, 32'h0);
      check_eq("t6_do_read", 32'(flash_do_read), 32'd0);
      check_eq("t6_flash_addr", 32'(flash_addr), 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (15) @(negedge clk);
      check_eq("t6_no_resp", 32'(resp_seen), 32'd0);

      // Re-boot with no requests: third completed word overflows and stops the stream
      n = 0;
      while (!(good_bytes > 0 && !flash_do_read) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check_eq("t4_stop_timeout", 32'(n < 300), 32'd1);
      // 12 bytes assembled plus the one in flight when do_read fell
      check_eq("t4_stop_bytes", 32'(good_bytes), 32'd13);
      do_req(24'h000000, d, lat);
      check_eq("t4_data0", d, 32'h03020100);
      check_eq("t4_latency0", 32'(lat), 32'd1);
      do_req(24'h000004, d, lat);
      check_eq("t4_data4", d, 32'h07060504);
      check_eq("t4_latency4", 32'(lat), 32'd1);
      do_req(24'h000008, d, lat);
      check_eq("t4_data8", d, 32'h0B0A0908);
      check_eq("t4_restart_addr", 32'(flash_addr), 32'h000008);
      check_eq("t4_restart_slow", 32'(lat > 1), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
